// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - packet reduction sink: sums beats in a guard-extended accumulator, saturates at close
module psum_collector #(
    parameter int BIT_WIDTH = 18,
    parameter int GUARD     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GUARD:0]       out_count,
    output logic                 out_sat,
    output logic                 out_trunc
);

    localparam int AW = BIT_WIDTH + GUARD;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]        acc;
    logic [AW-1:0]        sum;
    logic [GUARD-1:0]     cnt;
    logic                 accept;
    logic                 forced;
    logic                 close_pkt;
    logic [GUARD:0]       sum_hi;
    logic                 fits;
    logic [BIT_WIDTH-1:0] clamped;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // cnt holds beats already accumulated, so all-ones means this beat is number 2^GUARD
    assign forced    = &cnt;
    assign close_pkt = accept && (in_last || forced);

    assign sum = acc + {{GUARD{in_data[BIT_WIDTH-1]}}, in_data};

    // The sum fits the result width when every bit above the result's sign bit matches it
    assign sum_hi  = sum[AW-1:BIT_WIDTH-1];
    assign fits    = (sum_hi == '0) || (sum_hi == '1);
    assign clamped = fits ? sum[BIT_WIDTH-1:0]
                   : (sum[AW-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                : {1'b0, {(BIT_WIDTH-1){1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (close_pkt) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            if (close_pkt) begin
                acc       <= '0;
                cnt       <= '0;
                out_data  <= clamped;
                out_count <= {1'b0, cnt} + (GUARD+1)'(1);
                out_sat   <= !fits;
                out_trunc <= forced && !in_last;
            end else begin
                acc <= sum;
                cnt <= cnt + GUARD'(1);
            end
        end
    end

endmodule
